// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler bus: control/random inputs towards the scheduler and
// slot/state outputs towards collision detector and renderer.
interface obstacle_scheduler_if #(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned POS_W     = 10
);
  logic                        tick;
  logic                        cmd_start;
  logic                        cmd_end;
  logic                        cmd_reset;
  logic [6:0]                  rand_val;
  logic [NUM_SLOTS*POS_W-1:0]  slot_pos;
  logic [NUM_SLOTS*3-1:0]      slot_type;
  logic [NUM_SLOTS-1:0]        slot_en;
  logic [2:0]                  speed;
  logic [1:0]                  state;
  logic                        spawn_pulse;
  logic                        full;

  // Game controller side: issues commands and random values, observes slots.
  modport master (
    output tick, cmd_start, cmd_end, cmd_reset, rand_val,
    input  slot_pos, slot_type, slot_en, speed, state, spawn_pulse, full
  );

  // Scheduler side.
  modport slave (
    input  tick, cmd_start, cmd_end, cmd_reset, rand_val,
    output slot_pos, slot_type, slot_en, speed, state, spawn_pulse, full
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: game-state machine plus obstacle slot spawner/scroller.
// Optional feature macro: OBST_SPEED_RAMP_EN (speed ramps up with executed
// steps; when undefined the scroll speed is constant 1).
module obstacle_scheduler #(
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned SPAWN_X     = 640,
  parameter int unsigned MIN_GAP     = 350,
  parameter int unsigned GAP_BACKOFF = 50,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned RAMP_TICKS  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  obstacle_scheduler_if.slave  bus
);

  localparam int unsigned GAP_W     = $clog2(MIN_GAP + 1);
  localparam logic [2:0]  TYPE_NONE = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_END   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // Parameter sanity checks at elaboration.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
    $error("obstacle_scheduler: NUM_SLOTS must be 1..8");
  end
  if (SPAWN_X + 77 >= (2 ** POS_W)) begin : g_bad_spawn_x
    $error("obstacle_scheduler: SPAWN_X + 77 does not fit in POS_W bits");
  end
  if (MAX_SPEED < 1 || MAX_SPEED > 7) begin : g_bad_speed
    $error("obstacle_scheduler: MAX_SPEED must be 1..7");
  end
  if (RAMP_TICKS < 1) begin : g_bad_ramp
    $error("obstacle_scheduler: RAMP_TICKS must be at least 1");
  end
  if (MIN_GAP < 1 || GAP_BACKOFF > MIN_GAP) begin : g_bad_gap
    $error("obstacle_scheduler: need MIN_GAP >= 1 and GAP_BACKOFF <= MIN_GAP");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [POS_W-1:0]      r_pos      [NUM_SLOTS];
  logic [POS_W-1:0]      w_pos_nxt  [NUM_SLOTS];
  logic [2:0]            r_type     [NUM_SLOTS];
  logic [2:0]            w_type_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_en;
  logic [NUM_SLOTS-1:0]  w_en_nxt;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic [2:0]            r_pend_type;
  logic [2:0]            w_pend_type_nxt;
  logic [6:0]            r_pend_off;
  logic [6:0]            w_pend_off_nxt;
  logic                  r_spawn;
  logic                  w_spawn_nxt;
  logic                  w_placed;
  logic                  w_step;
  logic                  w_clear;
  logic [2:0]            w_speed;
  logic [POS_W-1:0]      w_speed_pos;
  logic [NUM_SLOTS*POS_W-1:0] w_slot_pos;
  logic [NUM_SLOTS*3-1:0]     w_slot_type;

  // Game-state transitions; reset outranks end, end outranks start.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.cmd_reset) begin
      w_state_nxt = ST_CLEAR;
    end else begin
      case (r_state)
        ST_INIT:  if (bus.cmd_start) w_state_nxt = ST_RUN;
        ST_RUN:   if (bus.cmd_end)   w_state_nxt = ST_END;
        ST_END:   if (bus.cmd_start) w_state_nxt = ST_CLEAR;
        ST_CLEAR: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_INIT;
      endcase
    end
  end

  // A step runs only on a RUN tick that is not overridden by end/reset.
  assign w_step      = (r_state == ST_RUN) && bus.tick && !bus.cmd_end && !bus.cmd_reset;
  assign w_clear     = (w_state_nxt == ST_CLEAR);
  assign w_speed_pos = POS_W'(w_speed);

  // Step datapath: move, gap accounting, spawn decision (all from pre-step values).
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_pos_nxt[i]  = r_pos[i];
      w_type_nxt[i] = r_type[i];
    end
    w_en_nxt        = r_en;
    w_gap_nxt       = r_gap;
    w_pend_type_nxt = r_pend_type;
    w_pend_off_nxt  = r_pend_off;
    w_spawn_nxt     = 1'b0;
    w_placed        = 1'b0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_en[i]) begin
        if (r_pos[i] <= w_speed_pos) begin
          w_en_nxt[i]   = 1'b0;
          w_type_nxt[i] = TYPE_NONE;
          w_pos_nxt[i]  = '0;
        end else begin
          w_pos_nxt[i]  = r_pos[i] - w_speed_pos;
        end
      end
    end

    if (&r_en) begin
      w_gap_nxt = '0;
    end else if (r_gap < GAP_W'(MIN_GAP)) begin
      w_gap_nxt = r_gap + GAP_W'(1);
    end else begin
      if (r_pend_type != TYPE_NONE) begin
        // Slots freed by this step's move are not candidates (r_en is pre-step).
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (!r_en[i] && !w_placed) begin
            w_en_nxt[i]   = 1'b1;
            w_type_nxt[i] = r_pend_type;
            w_pos_nxt[i]  = POS_W'(SPAWN_X) + POS_W'(r_pend_off);
            w_placed      = 1'b1;
          end
        end
        w_gap_nxt   = '0;
        w_spawn_nxt = 1'b1;
      end else begin
        w_gap_nxt = GAP_W'(MIN_GAP - GAP_BACKOFF);
      end

      if (bus.rand_val <= 7'd50) begin
        w_pend_type_nxt = 3'd5; w_pend_off_nxt = 7'd0;
      end else if (bus.rand_val <= 7'd60) begin
        w_pend_type_nxt = 3'd4; w_pend_off_nxt = 7'd27;
      end else if (bus.rand_val <= 7'd70) begin
        w_pend_type_nxt = 3'd2; w_pend_off_nxt = 7'd19;
      end else if (bus.rand_val <= 7'd80) begin
        w_pend_type_nxt = 3'd3; w_pend_off_nxt = 7'd77;
      end else if (bus.rand_val <= 7'd90) begin
        w_pend_type_nxt = 3'd0; w_pend_off_nxt = 7'd47;
      end else begin
        w_pend_type_nxt = 3'd1; w_pend_off_nxt = 7'd47;
      end
    end
  end

  // State, slots, gap, pending draw and spawn pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_pos[i]  <= '0;
        r_type[i] <= TYPE_NONE;
      end
      r_en        <= '0;
      r_gap       <= '0;
      r_pend_type <= TYPE_NONE;
      r_pend_off  <= '0;
      r_spawn     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_spawn <= 1'b0;
      if (w_clear) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          r_pos[i]  <= '0;
          r_type[i] <= TYPE_NONE;
        end
        r_en        <= '0;
        r_gap       <= '0;
        r_pend_type <= TYPE_NONE;
        r_pend_off  <= '0;
      end else if (w_step) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          r_pos[i]  <= w_pos_nxt[i];
          r_type[i] <= w_type_nxt[i];
        end
        r_en        <= w_en_nxt;
        r_gap       <= w_gap_nxt;
        r_pend_type <= w_pend_type_nxt;
        r_pend_off  <= w_pend_off_nxt;
        r_spawn     <= w_spawn_nxt;
      end
    end
  end

`ifdef OBST_SPEED_RAMP_EN
  localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  logic [RAMP_W-1:0] r_ramp;
  logic [2:0]        r_speed;

  // Speed ramp: one speed step per RAMP_TICKS executed steps, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp  <= '0;
      r_speed <= 3'd1;
    end else if (w_clear) begin
      r_ramp  <= '0;
      r_speed <= 3'd1;
    end else if (w_step) begin
      if (r_ramp == RAMP_W'(RAMP_TICKS - 1)) begin
        r_ramp <= '0;
        if (r_speed < 3'(MAX_SPEED)) r_speed <= r_speed + 3'd1;
      end else begin
        r_ramp <= r_ramp + RAMP_W'(1);
      end
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = 3'd1;
`endif

  // Pack slot arrays onto the bus, slot 0 in the LSBs.
  always_comb begin
    w_slot_pos  = '0;
    w_slot_type = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_slot_pos[i*POS_W +: POS_W] = r_pos[i];
      w_slot_type[i*3 +: 3]        = r_type[i];
    end
  end

  assign bus.slot_pos    = w_slot_pos;
  assign bus.slot_type   = w_slot_type;
  assign bus.slot_en     = r_en;
  assign bus.speed       = w_speed;
  assign bus.state       = 2'(r_state);
  assign bus.spawn_pulse = r_spawn;
  assign bus.full        = &r_en;

endmodule
